// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer
//   Front/back stage for an external combinational ALU. Holds a 2**AW entry
//   register file, accepts one instruction at a time over valid/ready, drives
//   registered operands plus op select to the ALU, then writes the ALU result
//   back to the destination register one cycle later and pulses done.
//
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     instr_valid/    instruction handshake; instr = {op[1:0], rd, rs1, rs2}
//     instr_ready
//     ld_en/ld_addr/  external register load, honoured in every state
//     ld_data
//     alu_a/alu_b/    registered operands and op select to the ALU
//     alu_choice
//     alu_result      combinational ALU result
//     done            one-cycle pulse in the cycle after writeback
//     wb_data/wb_addr last written-back value and destination
//     zero_flag       (only with ALU_SEQ_ZERO_FLAG_EN) last result was zero
//
//   Optional feature macro: ALU_SEQ_ZERO_FLAG_EN
module alu_operand_sequencer #(
    parameter int WIDTH = 18,
    parameter int AW    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [2+3*AW-1:0]   instr,
    input  logic                ld_en,
    input  logic [AW-1:0]       ld_addr,
    input  logic [WIDTH-1:0]    ld_data,
    output logic [WIDTH-1:0]    alu_a,
    output logic [WIDTH-1:0]    alu_b,
    output logic [1:0]          alu_choice,
    input  logic [WIDTH-1:0]    alu_result,
    output logic                done,
    output logic [WIDTH-1:0]    wb_data,
    output logic [AW-1:0]       wb_addr
`ifdef ALU_SEQ_ZERO_FLAG_EN
    ,
    output logic                zero_flag
`endif
);

    localparam int DEPTH = 1 << AW;
    localparam int IW    = 2 + 3 * AW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [DEPTH-1:0][WIDTH-1:0]   rf_q, rf_d;
    logic [WIDTH-1:0]              alu_a_q, alu_a_d;
    logic [WIDTH-1:0]              alu_b_q, alu_b_d;
    logic [1:0]                    alu_choice_q, alu_choice_d;
    logic [AW-1:0]                 rd_q, rd_d;
    logic                          done_q, done_d;
    logic [WIDTH-1:0]              wb_data_q, wb_data_d;
    logic [AW-1:0]                 wb_addr_q, wb_addr_d;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic                          zero_flag_q, zero_flag_d;
`endif

    // instruction fields
    logic [1:0]    f_op;
    logic [AW-1:0] f_rd, f_rs1, f_rs2;
    assign f_op  = instr[IW-1 -: 2];
    assign f_rd  = instr[3*AW-1 -: AW];
    assign f_rs1 = instr[2*AW-1 -: AW];
    assign f_rs2 = instr[AW-1:0];

    logic accept, wb_fire;
    assign accept  = (state_q == S_IDLE) && instr_valid;
    assign wb_fire = (state_q == S_EXEC);

    // next state and datapath registers
    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_choice_d = alu_choice_q;
        rd_d         = rd_q;
        wb_data_d    = wb_data_q;
        wb_addr_d    = wb_addr_q;
        done_d       = 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
        zero_flag_d  = zero_flag_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    // operands read from pre-edge register contents
                    alu_a_d      = rf_q[f_rs1];
                    alu_b_d      = rf_q[f_rs2];
                    alu_choice_d = f_op;
                    rd_d         = f_rd;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                wb_data_d = alu_result;
                wb_addr_d = rd_q;
                done_d    = 1'b1;
`ifdef ALU_SEQ_ZERO_FLAG_EN
                zero_flag_d = (alu_result == '0);
`endif
                state_d   = S_WB;
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // register file: writeback takes priority over an external load to the
    // same entry; loads to other entries proceed in parallel
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rf_d[i] = rf_q[i];
            if (wb_fire && (rd_q == AW'(i)))
                rf_d[i] = alu_result;
            else if (ld_en && (ld_addr == AW'(i)))
                rf_d[i] = ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rf_q         <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_choice_q <= '0;
            rd_q         <= '0;
            done_q       <= 1'b0;
            wb_data_q    <= '0;
            wb_addr_q    <= '0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            zero_flag_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            rf_q         <= rf_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_choice_q <= alu_choice_d;
            rd_q         <= rd_d;
            done_q       <= done_d;
            wb_data_q    <= wb_data_d;
            wb_addr_q    <= wb_addr_d;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            zero_flag_q  <= zero_flag_d;
`endif
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_choice  = alu_choice_q;
    assign done        = done_q;
    assign wb_data     = wb_data_q;
    assign wb_addr     = wb_addr_q;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    assign zero_flag   = zero_flag_q;
`endif

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: reference ALU, transaction-level model,
// per-cycle compare on the falling edge, and directed vectors with literal
// expectations.
module tb_alu_operand_sequencer;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  instr;
    logic        ld_en;
    logic [1:0]  ld_addr;
    logic [17:0] ld_data;
    logic [17:0] alu_a, alu_b;
    logic [1:0]  alu_choice;
    logic [17:0] alu_result;
    logic        done;
    logic [17:0] wb_data;
    logic [1:0]  wb_addr;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic        zero_flag;
`endif

    alu_operand_sequencer #(.WIDTH(18), .AW(2)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_choice(alu_choice),
        .alu_result(alu_result),
        .done(done), .wb_data(wb_data), .wb_addr(wb_addr)
`ifdef ALU_SEQ_ZERO_FLAG_EN
        , .zero_flag(zero_flag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] alu_f(input logic [1:0] op, input logic [17:0] a, input logic [17:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a & b;
            2'b10:   return a | b;
            default: return a ^ b;
        endcase
    endfunction

    // external ALU
    always_comb alu_result = alu_f(alu_choice, alu_a, alu_b);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic [17:0] m_reg [4];
    logic [17:0] m_a, m_b, m_res, m_wb_data;
    logic [1:0]  m_op, m_rd, m_wb_addr;
    logic        m_done, m_zero, m_on;
    int          cyc, acc_cyc;

    initial begin
        m_on = 1'b0;
        cyc = 0;
        acc_cyc = -10;
    end

    always @(posedge clk) begin
        logic [17:0] nreg [4];
        if (rst) begin
            for (int i = 0; i < 4; i++) m_reg[i] = '0;
            m_a = '0; m_b = '0; m_op = '0; m_rd = '0; m_res = '0;
            m_wb_data = '0; m_wb_addr = '0; m_done = 1'b0; m_zero = 1'b0;
            acc_cyc = -10;
            m_on = 1'b1;
        end else begin
            for (int i = 0; i < 4; i++) nreg[i] = m_reg[i];
            if (ld_en) nreg[ld_addr] = ld_data;
            m_done = 1'b0;
            // writeback one edge after acceptance, overriding any load
            if (cyc - acc_cyc == 1) begin
                nreg[m_rd] = m_res;
                m_wb_data  = m_res;
                m_wb_addr  = m_rd;
                m_done     = 1'b1;
                m_zero     = (m_res == 0);
            end
            if ((cyc - acc_cyc >= 3) && instr_valid) begin
                m_op  = instr[7:6];
                m_rd  = instr[5:4];
                m_a   = m_reg[instr[3:2]];
                m_b   = m_reg[instr[1:0]];
                m_res = alu_f(m_op, m_a, m_b);
                acc_cyc = cyc;
            end
            for (int i = 0; i < 4; i++) m_reg[i] = nreg[i];
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (m_on) begin
            check("ready", {31'b0, instr_ready}, {31'b0, (cyc - acc_cyc >= 3)});
            check("done", {31'b0, done}, {31'b0, m_done});
            check("alu_a", {14'b0, alu_a}, {14'b0, m_a});
            check("alu_b", {14'b0, alu_b}, {14'b0, m_b});
            check("alu_choice", {30'b0, alu_choice}, {30'b0, m_op});
            check("wb_data", {14'b0, wb_data}, {14'b0, m_wb_data});
            check("wb_addr", {30'b0, wb_addr}, {30'b0, m_wb_addr});
`ifdef ALU_SEQ_ZERO_FLAG_EN
            check("zero_flag", {31'b0, zero_flag}, {31'b0, m_zero});
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] a, input logic [17:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        step();
        ld_en = 1'b0;
    endtask

    // waits (bounded) for ready, presents one instruction, returns in EXEC
    task automatic issue(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2);
        int n;
        n = 0;
        while (!instr_ready && n < 10) begin
            step();
            n++;
        end
        if (!instr_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout: ready stayed %b expected 1", instr_ready);
        end
        instr_valid = 1'b1;
        instr = {op, rd, rs1, rs2};
        step();
        instr_valid = 1'b0;
    endtask

    initial begin
        int acc_n, dn_n;
        int acc_idx [3];
        rst = 1'b1; instr_valid = 1'b0; instr = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        step(); step();
        rst = 1'b0;
        check("rst_ready", {31'b0, instr_ready}, 32'd1);
        check("rst_wb_data", {14'b0, wb_data}, 32'h0);

        // add with wrap
        load(2'd1, 18'h3FFFF);
        load(2'd2, 18'h00001);
        issue(2'b00, 2'd3, 2'd1, 2'd2);
        check("add_a", {14'b0, alu_a}, 32'h3FFFF);
        check("add_b", {14'b0, alu_b}, 32'h00001);
        step();
        check("add_done", {31'b0, done}, 32'd1);
        check("add_wb", {14'b0, wb_data}, 32'h00000);
        check("add_wbaddr", {30'b0, wb_addr}, 32'd3);
`ifdef ALU_SEQ_ZERO_FLAG_EN
        check("add_zero", {31'b0, zero_flag}, 32'd1);
`endif
        step();

        // logic ops
        load(2'd0, 18'h2AAAA);
        load(2'd1, 18'h15555);
        issue(2'b01, 2'd2, 2'd0, 2'd1); step();
        check("and_wb", {14'b0, wb_data}, 32'h00000);
        step();
        issue(2'b10, 2'd2, 2'd0, 2'd1); step();
        check("or_wb", {14'b0, wb_data}, 32'h3FFFF);
        check("or_wbaddr", {30'b0, wb_addr}, 32'd2);
        step();
        issue(2'b11, 2'd2, 2'd0, 2'd1); step();
        check("xor_wb", {14'b0, wb_data}, 32'h3FFFF);
        step();

        // back-to-back handshake with valid held high
        acc_n = 0; dn_n = 0;
        instr_valid = 1'b1;
        instr = {2'b00, 2'd3, 2'd3, 2'd2};
        for (int i = 0; i < 9; i++) begin
            if (instr_ready) begin
                if (acc_n < 3) acc_idx[acc_n] = i;
                acc_n++;
            end
            step();
            if (done) dn_n++;
        end
        instr_valid = 1'b0;
        check("hs_accepts", acc_n, 32'd3);
        check("hs_dones", dn_n, 32'd3);
        check("hs_spacing1", acc_idx[1] - acc_idx[0], 32'd3);
        check("hs_spacing2", acc_idx[2] - acc_idx[1], 32'd3);

        // load/writeback collision, same address: writeback wins
        load(2'd0, 18'h00010);
        issue(2'b00, 2'd1, 2'd0, 2'd0);
        ld_en = 1'b1; ld_addr = 2'd1; ld_data = 18'h12345;
        instr = 8'hFF;      // ignored outside acceptance
        step();
        ld_en = 1'b0;
        check("col1_wb", {14'b0, wb_data}, 32'h00020);
        step();
        issue(2'b00, 2'd3, 2'd1, 2'd1);
        check("col1_r1", {14'b0, alu_a}, 32'h00020);
        step(); step();

        // different addresses: both written
        issue(2'b00, 2'd1, 2'd0, 2'd0);
        ld_en = 1'b1; ld_addr = 2'd0; ld_data = 18'h12345;
        step();
        ld_en = 1'b0;
        step();
        issue(2'b10, 2'd3, 2'd0, 2'd1);
        check("col2_r0", {14'b0, alu_a}, 32'h12345);
        check("col2_r1", {14'b0, alu_b}, 32'h00020);
        step(); step();

        // read-before-write at the acceptance edge
        load(2'd2, 18'h00001);
        ld_en = 1'b1; ld_addr = 2'd2; ld_data = 18'h00007;
        issue(2'b01, 2'd3, 2'd2, 2'd2);
        ld_en = 1'b0;
        check("rbw_old", {14'b0, alu_a}, 32'h00001);
        step(); step();
        issue(2'b00, 2'd0, 2'd2, 2'd1);
        check("rbw_new", {14'b0, alu_a}, 32'h00007);
        step(); step();

        // reset in the middle of EXEC: no writeback, everything cleared
        issue(2'b00, 2'd3, 2'd2, 2'd2);
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        check("mrst_ready", {31'b0, instr_ready}, 32'd1);
        check("mrst_done", {31'b0, done}, 32'd0);
        check("mrst_a", {14'b0, alu_a}, 32'h0);
        check("mrst_wb", {14'b0, wb_data}, 32'h0);
        check("mrst_wbaddr", {30'b0, wb_addr}, 32'd0);
        issue(2'b00, 2'd0, 2'd2, 2'd1);
        check("mrst_reg_a", {14'b0, alu_a}, 32'h0);
        step();
        check("mrst_reg_wb", {14'b0, wb_data}, 32'h0);
        check("mrst_reg_done", {31'b0, done}, 32'd1);
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
Upstream/downstream wrapper stage for the 18-bit combinational ALU (two operands, 2-bit op select, 18-bit result).
- Holds a small register file and accepts one instruction at a time over a valid/ready handshake.
- Reads the source registers and drives registered operands and op select into the external ALU.
- Captures the ALU result one cycle later and writes it back to the destination register, reporting completion.

Parameters:
WIDTH, 18, datapath width; must match the ALU operand/result width.
AW, 2, register address width; register file depth = 2**AW.

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
instr_valid  input  1  instruction present
instr_ready  output  1  block can accept an instruction
instr  input  2+3*AW  {op[1:0], rd, rs1, rs2}, op in MSBs, rs2 in LSBs
ld_en  input  1  external register load strobe
ld_addr  input  AW  load address
ld_data  input  WIDTH  load data
alu_a  output  WIDTH  operand 1 to ALU
alu_b  output  WIDTH  operand 2 to ALU
alu_choice  output  2  op select to ALU (00 add, 01 and, 10 or, 11 xor)
alu_result  input  WIDTH  combinational result from ALU
done  output  1  one-cycle pulse, writeback performed
wb_data  output  WIDTH  value written back, held until next writeback
wb_addr  output  AW  destination of last writeback

Behaviour:
- Reset is synchronous and active-high. With rst=1 at a clock edge:
  - state goes to IDLE; all registers go to 0.
  - alu_a, alu_b, alu_choice, wb_data, wb_addr and done all go to 0.
  - rst overrides every other input, including reset in the middle of an operation; an in-flight instruction is discarded with no writeback.
- FSM states: IDLE -> EXEC -> WB -> IDLE.
- IDLE: instr_ready=1. On an edge with instr_valid=1:
  - alu_a <= reg[rs1], alu_b <= reg[rs2], alu_choice <= op, pending rd latched.
  - state <= EXEC.
  - With instr_valid=0, stay in IDLE and hold the outputs.
- EXEC: instr_ready=0. The ALU settles combinationally. At the edge:
  - reg[rd] <= alu_result, wb_data <= alu_result, wb_addr <= rd, done <= 1.
  - state <= WB.
- WB: instr_ready=0, done=1 for exactly this cycle. Next edge: done <= 0, state <= IDLE.
- Latency and throughput: done is high in the 2nd cycle after the acceptance edge. One instruction every 3 cycles.
- alu_a, alu_b and alu_choice hold their values from acceptance until the next acceptance.
- Register reads use pre-edge values. A load or writeback at the acceptance edge is not visible to that instruction.
- ld_en is honoured in every state: reg[ld_addr] <= ld_data.
- Load and writeback to the same address at the same edge: writeback wins. Different addresses: both are written.
- rs1 = rs2 is legal and both operands read the same register. rd may equal rs1 or rs2.
- Arithmetic is performed by the external ALU. Add wraps modulo 2**WIDTH and no carry is kept.
- instr is sampled only at the acceptance edge; changes at other times are ignored.

Optional Feature:
Macro ALU_SEQ_ZERO_FLAG_EN.
- Defined:
  - Adds output port zero_flag (1 bit), reset to 0.
  - At the EXEC edge, zero_flag <= (alu_result == 0); it holds until the next writeback.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset: assert rst for 2 cycles mid-EXEC -> done never pulses; all outputs 0; instr_ready=1 in the first cycle after release.
- Add with wrap: load r1=0x3FFFF, r2=0x00001, issue op=00 rd=3 rs1=1 rs2=2 -> alu_a=0x3FFFF, alu_b=0x00001 in EXEC. done 2 cycles after acceptance with wb_data=0x00000, wb_addr=3. zero_flag=1 if enabled.
- Logic ops: r0=0x2AAAA, r1=0x15555. Issue and (op=01) -> 0x00000; or (op=10) -> 0x3FFFF; xor (op=11) -> 0x3FFFF. Each issue follows the previous done, and each result is written to rd=2.
- Handshake: hold instr_valid=1 continuously -> acceptances exactly every 3 cycles, instr_ready low in EXEC and WB, one done per instruction.
- Load/writeback collision: instruction with rd=1 where ld_en=1, ld_addr=1, ld_data=0x12345 coincide with the EXEC edge -> reg[1] equals the ALU result. Repeat with ld_addr=0 -> reg[0]=0x12345 and reg[1]=ALU result.
- Read-before-write: ld_en writes r2=0x00007 at the acceptance edge of an instruction reading rs1=2 (old value 0x00001) -> alu_a=0x00001. The next instruction reading r2 sees 0x00007.
